// File: rtl/eth_pkg.sv
// Shared constants, state encoding and CRC step for the 10BASE-T receiver.
// Imported by the Manchester decoder and the framing top.
package eth_pkg;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [7:0]  PREAMBLE    = 8'h55;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_DATA = 1'b1
    } rx_state_t;

    function automatic logic [31:0] crc_step(
        input logic [31:0] c,
        input logic        b
    );
        return (c << 1) ^ ({32{b ^ c[31]}} & CRC_POLY);
    endfunction

endpackage

// File: rtl/eth_manchester_dec.sv
// Manchester line decoder: synchronizer, mid-bit edge timing,
// bit strobes and carrier-loss detection.
module eth_manchester_dec #(
    parameter int SPB = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic hunt,
    output logic lvl,
    output logic edge_seen,
    output logic bit_stb,
    output logic bit_val,
    output logic loss
);

    localparam int MID  = 3 * SPB / 4;
    localparam int LOSS = 3 * SPB / 2;
    localparam int CW   = $clog2(LOSS + 1);
    localparam logic [CW-1:0] MID_C  = CW'(MID);
    localparam logic [CW-1:0] LOSS_C = CW'(LOSS);

    logic          s1;
    logic          s2;
    logic          s3;
    logic          active;
    logic [CW-1:0] cnt;
    logic          mid;

    assign lvl       = s2;
    assign edge_seen = s2 ^ s3;
    // With no carrier being tracked, the first edge anchors bit timing.
    assign mid = edge_seen && ((hunt && !active) || (cnt >= MID_C));

    // Synchronize, time edges since last mid-bit, emit bits and loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            active  <= 1'b0;
            cnt     <= '0;
            bit_stb <= 1'b0;
            bit_val <= 1'b0;
            loss    <= 1'b0;
        end else begin
            s1      <= rx;
            s2      <= s1;
            s3      <= s2;
            bit_stb <= 1'b0;
            loss    <= 1'b0;
            if (mid) begin
                bit_stb <= 1'b1;
                bit_val <= s2;
                cnt     <= CW'(1);
                active  <= 1'b1;
            end else begin
                if (cnt != LOSS_C) begin
                    cnt <= cnt + 1'b1;
                end
                if (active && cnt == LOSS_C) begin
                    loss   <= 1'b1;
                    active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/eth_rx.sv
// 10BASE-T receive path: preamble/SFD hunt, byte assembly, CRC check,
// normal-link-pulse detection and link integrity timer.
module eth_rx
    import eth_pkg::*;
#(
    parameter int SPB          = 8,
    parameter int PRE_MIN      = 16,
    parameter int LINK_TIMEOUT = 4000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sof,
    output logic       rx_eof,
    output logic       rx_crc_ok,
    output logic       rx_err,
    output logic       link_ok
);

    localparam int RW = $clog2(PRE_MIN + 1);
    localparam int HW = $clog2(SPB + 2);
    localparam int QW = $clog2(2 * SPB + 1);
    localparam logic [RW-1:0] PRE_C  = RW'(PRE_MIN);
    localparam logic [HW-1:0] HMAX   = HW'(SPB + 1);
    localparam logic [HW-1:0] HLIM   = HW'(SPB);
    localparam logic [QW-1:0] QLAST  = QW'(2 * SPB - 1);
    localparam logic [31:0]   LT_END = 32'(LINK_TIMEOUT - 1);
    localparam logic          SFD_TAIL = SFD[7];

    rx_state_t     state;
    logic          lvl;
    logic          edge_seen;
    logic          bit_stb;
    logic          bit_val;
    logic          loss;
    logic [RW-1:0] run;
    logic          last_bit;
    logic [7:0]    sh;
    logic [2:0]    bit_cnt;
    logic [2:0]    byte_cnt;
    logic          first;
    logic [31:0]   crc;
    logic [HW-1:0] hcnt;
    logic [QW-1:0] qcnt;
    logic          armed;
    logic          nlp_hit;
    logic          good_eof;
    logic [31:0]   lcnt;

    eth_manchester_dec #(
        .SPB(SPB)
    ) u_dec (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .hunt     (state == ST_HUNT),
        .lvl      (lvl),
        .edge_seen(edge_seen),
        .bit_stb  (bit_stb),
        .bit_val  (bit_val),
        .loss     (loss)
    );

    assign nlp_hit = (state == ST_HUNT) && armed && !lvl
                     && !edge_seen && (qcnt == QLAST);
    assign good_eof = (state == ST_DATA) && loss
                      && (crc == CRC_RESIDUE);

    // Framing FSM: preamble hunt, byte assembly, CRC and end of frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HUNT;
            run       <= '0;
            last_bit  <= 1'b0;
            sh        <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            first     <= 1'b0;
            crc       <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_sof    <= 1'b0;
            rx_eof    <= 1'b0;
            rx_crc_ok <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            rx_sof    <= 1'b0;
            rx_eof    <= 1'b0;
            rx_crc_ok <= 1'b0;
            rx_err    <= 1'b0;
            unique case (state)
                ST_HUNT: begin
                    if (nlp_hit || loss) begin
                        run <= '0;
                    end else if (bit_stb) begin
                        last_bit <= bit_val;
                        if (run == '0 || bit_val != last_bit) begin
                            if (run != PRE_C) begin
                                run <= run + 1'b1;
                            end
                        end else if (bit_val == SFD_TAIL
                                     && run >= PRE_C) begin
                            state    <= ST_DATA;
                            run      <= '0;
                            crc      <= CRC_INIT;
                            sh       <= '0;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                            first    <= 1'b1;
                        end else begin
                            run <= RW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (loss) begin
                        rx_eof    <= 1'b1;
                        rx_crc_ok <= (crc == CRC_RESIDUE);
                        rx_err    <= (byte_cnt < 3'd5)
                                     || (bit_cnt != 3'd0);
                        state     <= ST_HUNT;
                        run       <= '0;
                    end else if (bit_stb) begin
                        crc     <= crc_step(crc, bit_val);
                        sh      <= {bit_val, sh[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= {bit_val, sh[7:1]};
                            rx_valid <= 1'b1;
                            rx_sof   <= first;
                            first    <= 1'b0;
                            if (byte_cnt != 3'd5) begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_HUNT;
            endcase
        end
    end

    // NLP detector: short high pulse in HUNT followed by a quiet line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt  <= '0;
            qcnt  <= '0;
            armed <= 1'b0;
        end else if (state != ST_HUNT) begin
            hcnt  <= '0;
            qcnt  <= '0;
            armed <= 1'b0;
        end else if (edge_seen && lvl) begin
            hcnt  <= HW'(1);
            qcnt  <= '0;
            armed <= 1'b0;
        end else if (edge_seen) begin
            armed <= (hcnt != '0) && (hcnt <= HLIM);
            qcnt  <= QW'(1);
        end else if (lvl) begin
            if (hcnt != HMAX) begin
                hcnt <= hcnt + 1'b1;
            end
        end else if (armed) begin
            if (qcnt == QLAST) begin
                armed <= 1'b0;
            end else begin
                qcnt <= qcnt + 1'b1;
            end
        end
    end

    // Link integrity: refreshed by NLPs and good frames, then times out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_ok <= 1'b0;
            lcnt    <= '0;
        end else if (nlp_hit || good_eof) begin
            link_ok <= 1'b1;
            lcnt    <= '0;
        end else if (link_ok) begin
            if (lcnt == LT_END) begin
                link_ok <= 1'b0;
            end else begin
                lcnt <= lcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx.sv
// Self-checking bench for eth_rx: Manchester line driver, zlib-style
// CRC32 reference and a byte-stream scoreboard.
module tb_eth_rx;
    import eth_pkg::*;

    localparam int SPB     = 8;
    localparam int PRE_MIN = 16;
    localparam int LT      = 10000;
    localparam int NLP_GAP = 4000;
    localparam int NLP_CNT = 4;

    typedef logic [7:0] bq_t[$];
    typedef bit bitq_t[$];

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sof;
    logic       rx_eof;
    logic       rx_crc_ok;
    logic       rx_err;
    logic       link_ok;

    eth_rx #(
        .SPB(SPB),
        .PRE_MIN(PRE_MIN),
        .LINK_TIMEOUT(LT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_sof   (rx_sof),
        .rx_eof   (rx_eof),
        .rx_crc_ok(rx_crc_ok),
        .rx_err   (rx_err),
        .link_ok  (link_ok)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    bit   abort  = 1'b0;

    logic [7:0] rxq[$];
    int   sof_n    = 0;
    int   sof_pos  = 0;
    int   eof_n    = 0;
    int   overlap  = 0;
    int   rise_n   = 0;
    int   fall_n   = 0;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    logic last_ok  = 1'b0;
    logic last_err = 1'b0;
    logic link_q   = 1'b0;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_sof) begin
                sof_n   <= sof_n + 1;
                sof_pos <= rxq.size();
            end
            rxq.push_back(rx_data);
        end
        if (rx_eof) begin
            eof_n    <= eof_n + 1;
            last_ok  <= rx_crc_ok;
            last_err <= rx_err;
            if (rx_valid) overlap <= overlap + 1;
        end
        if (link_ok && !link_q) begin
            rise_n   <= rise_n + 1;
            rise_cyc <= cyc;
        end
        if (!link_ok && link_q) begin
            fall_n   <= fall_n + 1;
            fall_cyc <= cyc;
        end
        link_q <= link_ok;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".data"}, 32'(rx_data), 32'h0);
        chk({tag, ".valid"}, 32'(rx_valid), 32'h0);
        chk({tag, ".sof"}, 32'(rx_sof), 32'h0);
        chk({tag, ".eof"}, 32'(rx_eof), 32'h0);
        chk({tag, ".crc_ok"}, 32'(rx_crc_ok), 32'h0);
        chk({tag, ".err"}, 32'(rx_err), 32'h0);
        chk({tag, ".link"}, 32'(link_ok), 32'h0);
    endtask

    function automatic logic [31:0] crc32(input bq_t d);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (d[i]) begin
            c = c ^ {24'h0, d[i]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bitq_t to_bits(input bq_t b);
        bitq_t q;
        foreach (b[i])
            for (int j = 0; j < 8; j++) q.push_back(b[i][j]);
        return q;
    endfunction

    function automatic bq_t with_pre(input bq_t body, input int npre);
        bq_t w;
        for (int i = 0; i < npre; i++) w.push_back(PREAMBLE);
        w.push_back(SFD);
        foreach (body[i]) w.push_back(body[i]);
        return w;
    endfunction

    // Each bit's mid edge and the following boundary share one jitter value.
    task automatic send_bits(input bitq_t bits, input bit jit);
        int e;
        int ep;
        ep = 0;
        foreach (bits[i]) begin
            if (abort) begin
                rx = 1'b0;
                return;
            end
            e  = jit ? int'($urandom_range(2)) - 1 : 0;
            rx = ~bits[i];
            repeat (SPB / 2 + e - ep) @(negedge clk);
            rx = bits[i];
            repeat (SPB / 2) @(negedge clk);
            ep = e;
        end
        repeat (3 * SPB) @(negedge clk);
        rx = 1'b0;
        repeat (6 * SPB) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input bq_t pay,
                             input bit fcs, input int extra,
                             input bit jit, input int flip);
        bq_t         body;
        bq_t         p;
        bitq_t       bits;
        logic [31:0] c;
        int          n;
        int          qb;
        int          eb;
        int          sb;
        bit          eok;
        bit          eerr;
        body = pay;
        if (fcs) begin
            c = crc32(pay);
            for (int k = 0; k < 4; k++) body.push_back(c[8*k +: 8]);
        end
        if (flip >= 0) body[flip] = body[flip] ^ 8'h08;
        n   = body.size();
        eok = 1'b0;
        if (extra == 0 && n >= 4) begin
            for (int k = 0; k < n - 4; k++) p.push_back(body[k]);
            eok = (crc32(p) == {body[n-1], body[n-2],
                                body[n-3], body[n-4]});
        end
        eerr = (n < 5) || (extra != 0);
        bits = to_bits(with_pre(body, 7));
        repeat (extra) bits.push_back(bit'($urandom_range(1)));
        qb = rxq.size();
        eb = eof_n;
        sb = sof_n;
        send_bits(bits, jit);
        chk({tag, ".len"}, 32'(rxq.size() - qb), 32'(n));
        for (int k = 0; k < n && qb + k < rxq.size(); k++)
            chk($sformatf("%s.b%0d", tag, k), 32'(rxq[qb+k]),
                32'(body[k]));
        chk({tag, ".sof_n"}, 32'(sof_n - sb), 32'(n > 0));
        if (n > 0) chk({tag, ".sof_pos"}, 32'(sof_pos), 32'(qb));
        chk({tag, ".eof_n"}, 32'(eof_n - eb), 32'h1);
        chk({tag, ".crc_ok"}, 32'(last_ok), 32'(eok));
        chk({tag, ".err"}, 32'(last_err), 32'(eerr));
    endtask

    initial begin
        bq_t   pay;
        bq_t   sh_b;
        bitq_t bits;
        int    t0;
        int    rb;
        int    fb;
        int    qb;
        int    eb;

        repeat (5) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (50) @(negedge clk);

        // Link pulses only.
        t0 = cyc;
        rb = rise_n;
        fb = fall_n;
        qb = rxq.size();
        eb = eof_n;
        for (int p = 0; p < NLP_CNT; p++) begin
            rx = 1'b1;
            repeat (SPB / 2) @(negedge clk);
            rx = 1'b0;
            repeat (NLP_GAP - SPB / 2) @(negedge clk);
        end
        repeat (LT - NLP_GAP + 3000) @(negedge clk);
        chk("nlp.rise_n", 32'(rise_n - rb), 32'h1);
        chk("nlp.rise_lat", 32'((rise_cyc - t0) <= 4 * SPB + 8), 32'h1);
        chk("nlp.fall_n", 32'(fall_n - fb), 32'h1);
        chk("nlp.fall_at", 32'(fall_cyc - rise_cyc),
            32'((NLP_CNT - 1) * NLP_GAP + LT));
        chk("nlp.bytes", 32'(rxq.size() - qb), 32'h0);
        chk("nlp.eof", 32'(eof_n - eb), 32'h0);

        for (int i = 0; i <= 8'h3B; i++) pay.push_back(8'(i));
        run_frame("good", pay, 1'b1, 0, 1'b0, -1);
        run_frame("flip", pay, 1'b1, 0, 1'b0, 16);
        run_frame("jit", pay, 1'b1, 0, 1'b1, -1);

        // Reset in the middle of a frame.
        chk("rst.link_pre", 32'(link_ok), 32'h1);
        begin
            bq_t b;
            logic [31:0] c;
            b = pay;
            c = crc32(pay);
            for (int k = 0; k < 4; k++) b.push_back(c[8*k +: 8]);
            bits = to_bits(with_pre(b, 7));
        end
        qb = rxq.size();
        eb = eof_n;
        fork
            send_bits(bits, 1'b0);
            begin
                for (int i = 0; i < 3000 && rxq.size() < qb + 10; i++)
                    @(negedge clk);
                chk("rst.byte10", 32'(rxq.size() - qb), 32'd10);
                #2 rst_n = 1'b0;
                #1 chk_zero("rst");
                abort = 1'b1;
                repeat (20) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        abort = 1'b0;
        repeat (100) @(negedge clk);
        chk("rst.no_eof", 32'(eof_n - eb), 32'h0);
        chk("rst.bytes", 32'(rxq.size() - qb), 32'd10);
        run_frame("rst_next", pay, 1'b1, 0, 1'b0, -1);

        // Too few preamble bits before SFD.
        sh_b.push_back(PREAMBLE);
        sh_b.push_back(SFD);
        for (int i = 0; i < 4; i++) sh_b.push_back(8'(i));
        qb = rxq.size();
        eb = eof_n;
        send_bits(to_bits(sh_b), 1'b0);
        chk("short.bytes", 32'(rxq.size() - qb), 32'h0);
        chk("short.eof", 32'(eof_n - eb), 32'h0);

        // Random frames: length, FCS presence, trailing bits, jitter.
        for (int f = 0; f < 6; f++) begin
            bq_t rp;
            int  len;
            int  extra;
            len   = int'($urandom_range(20));
            extra = ($urandom_range(3) == 0)
                    ? int'($urandom_range(7, 1)) : 0;
            for (int i = 0; i < len; i++) rp.push_back(8'($urandom));
            run_frame($sformatf("rnd%0d", f), rp,
                      bit'($urandom_range(1)), extra,
                      bit'($urandom_range(1)), -1);
        end

        chk("eof_valid_overlap", 32'(overlap), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
